return_arbiter: RTL and testbench
=================================

# return_arbiter

- Master-side arbiter for one return channel (R or B) of the crossbar.
- Selects which slave-interface return FIFO feeds this master's return FIFO, and drives the grant number and push strobe that the slave interfaces use to pop.
- Round-robin across slaves, with optional burst lock that holds a grant until the RLAST beat.
- Instantiate once per master per return channel. For the B channel, tie `slave_front_last` high.

## Interface

Parameters:
- `masters`, default 2: number of masters; must be ≥ 2.
- `slaves`, default 2: number of slaves; must be ≥ 2.
- `i_am_master_number`, default 0: this master's index.

Ports (reset is synchronous, active-high):
- `ACLK` in 1: clock.
- `ARESET` in 1: synchronous active-high reset.
- `slave_fifo_empty [0:slaves-1]` in 1 each: return FIFO empty flag of each slave interface.
- `slave_return_dest_master [0:slaves-1]` in `$clog2(masters)` each: destination master decoded from the front entry's ID.
- `slave_front_last [0:slaves-1]` in 1 each: front entry is the last beat (RLAST).
- `master_fifo_full` in 1: this master's return FIFO is full.
- `grant_slave_number` out `$clog2(slaves)`: currently granted slave.
- `push_to_fifo` out 1: the granted slave's front entry transfers this cycle.
- `grant_valid` out 1: arbiter is in LOCK state.

## Operation

- Request: `req[s] = ~slave_fifo_empty[s] & (slave_return_dest_master[s] == i_am_master_number)`.
- State machine has two states, IDLE and LOCK.
- **IDLE**:
  - `push_to_fifo = 0`.
  - If any `req` is set, latch the round-robin winner into `grant_slave_number` and go to LOCK.
  - Winner = first requesting slave scanning upward from `rr_ptr`, with wrap-around modulo `slaves`.
  - If no `req`, stay in IDLE and hold `grant_slave_number`.
- **LOCK**:
  - `push_to_fifo = req[grant_slave_number] & ~master_fifo_full`, combinational from registered state.
  - On a push with `slave_front_last[grant]=1`: go to IDLE and set `rr_ptr <= (grant+1) mod slaves`.
  - On a push with last=0: stay in LOCK.
  - If the granted FIFO goes empty or full is asserted, hold LOCK with push=0. Never re-arbitrate mid-burst.
- `grant_valid = (state == LOCK)`.
- `rr_ptr` increment wraps: `slaves-1 → 0`. Non-power-of-two `slaves` must wrap explicitly.
- `grant_slave_number` changes only on the IDLE→LOCK transition.

## Timing

- Reset values:
  - state = IDLE.
  - `grant_slave_number = 0`.
  - `rr_ptr = 0`.
  - `push_to_fifo = 0`.
  - `grant_valid = 0`.
- Arbitration latency: request visible in cycle N → grant registered at edge N+1 → first push possible in cycle N+1.
- Throughput: one beat per cycle within a burst. After a last beat there is one IDLE bubble cycle before the next grant.
- `master_fifo_full` and `push_to_fifo` may both be sampled in the same cycle; full always wins, so push=0.
- Reset asserted mid-burst: next cycle is IDLE with all outputs at reset values. The partially transferred burst is abandoned; upstream FIFOs are reset by the same reset.
- Simultaneous requests from all slaves: exactly one grant, chosen from `rr_ptr`.

## Configuration

- Macro: `RETURN_ARB_BURST_LOCK_EN`.
- Defined: behaviour is as described above; the grant is held until the push of a beat with `slave_front_last=1`.
- Undefined: every push returns the arbiter to IDLE and advances `rr_ptr`, regardless of `slave_front_last`. Beats of different bursts may interleave; this is only legal with per-ID reordering downstream. `slave_front_last` is ignored.

## Test plan

- **Reset**: hold `ARESET=1` for 3 cycles with all FIFOs non-empty → `push_to_fifo=0`, `grant_valid=0`, `grant_slave_number=0` throughout. First grant goes to slave 0 one cycle after reset deasserts.
- **Round-robin**: slaves 0 and 1 both request single-beat (last=1) entries continuously → grants alternate 0,1,0,1. Each push is followed by one bubble cycle.
- **Burst lock**: slave 1 holds a 4-beat burst (last on beat 4) while slave 0 also requests → 4 consecutive pushes from slave 1, then the grant moves to slave 0. With the macro undefined, grants alternate per beat.
- **Backpressure**: `master_fifo_full=1` for 5 cycles mid-burst → `push_to_fifo=0` for those cycles and the grant is unchanged. The burst resumes the cycle after full drops.
- **Destination filter**: slave 0 is non-empty but its dest = other master → no grant. When dest switches to `i_am_master_number`, grant arrives the next cycle.
- **Reset mid-burst**: assert reset after beat 2 of 4 → state returns to IDLE and outputs take reset values the following cycle.

Source files
------------

// File: rtl/return_arbiter.sv
// ============================================================================
// return_arbiter : round-robin selector of slave return FIFOs for one master
//                  return channel; optional burst lock via RETURN_ARB_BURST_LOCK_EN
// Revision       : 1.0
// ============================================================================
`default_nettype none

module return_arbiter #(
  parameter int masters            = 2,
  parameter int slaves             = 2,
  parameter int i_am_master_number = 0
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       slave_fifo_empty         [0:slaves-1],
  input  logic [$clog2(masters)-1:0] slave_return_dest_master [0:slaves-1],
  input  logic                       slave_front_last         [0:slaves-1],
  input  logic                       master_fifo_full,
  output logic [$clog2(slaves)-1:0]  grant_slave_number,
  output logic                       push_to_fifo,
  output logic                       grant_valid
);

  localparam int c_mw = $clog2(masters);
  localparam int c_sw = $clog2(slaves);
  localparam logic [c_mw-1:0] c_my_master  = c_mw'(i_am_master_number);
  localparam logic [c_sw-1:0] c_last_slave = c_sw'(slaves - 1);
  localparam logic [c_sw:0]   c_slaves_ext = (c_sw + 1)'(slaves);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            r_state;
  logic [c_sw-1:0]   r_grant;
  logic [c_sw-1:0]   r_rr_ptr;

  logic [slaves-1:0] w_req;
  logic              w_any;
  logic [c_sw-1:0]   w_winner;
  logic [c_sw:0]     w_sum;
  logic [c_sw-1:0]   w_idx;
  logic              w_push;
  logic              w_last;
  logic [c_sw-1:0]   w_next_ptr;

  for (genvar s = 0; s < slaves; s++) begin : g_req
    assign w_req[s] = ~slave_fifo_empty[s] &
                      (slave_return_dest_master[s] == c_my_master);
  end

  // Scan upward from rr_ptr; the sum is one bit wider so the modulo wrap
  // also works when slaves is not a power of two.
  always_comb begin
    w_any    = 1'b0;
    w_winner = r_grant;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < slaves; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (c_sw + 1)'(k);
      if (w_sum >= c_slaves_ext) begin
        w_sum = w_sum - c_slaves_ext;
      end
      w_idx = w_sum[c_sw-1:0];
      if (!w_any && w_req[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

`ifdef RETURN_ARB_BURST_LOCK_EN
  assign w_last = slave_front_last[r_grant];
`else
  logic w_unused_last;
  assign w_unused_last = slave_front_last[r_grant];
  assign w_last        = 1'b1;
`endif

  assign w_push     = (r_state == LOCK) & w_req[r_grant] & ~master_fifo_full;
  assign w_next_ptr = (r_grant == c_last_slave) ? '0 : r_grant + 1'b1;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_winner;
            r_state <= LOCK;
          end
        end
        LOCK: begin
          // An empty or backpressured grant holds here; no mid-burst re-arbitration.
          if (w_push && w_last) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_slave_number = r_grant;
  assign push_to_fifo       = w_push;
  assign grant_valid        = (r_state == LOCK);

endmodule

`default_nettype wire

// File: tb/tb_return_arbiter.sv
// Directed bench for return_arbiter: 3 slaves, 2 masters, this master = 1.
`default_nettype none

module tb_return_arbiter;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       empty [0:2];
  logic [0:0] dest  [0:2];
  logic       last  [0:2];
  logic       full;
  logic [1:0] grant_slave_number;
  logic       push_to_fifo;
  logic       grant_valid;

  int n_compared;
  int n_mismatched;

  always #5 ACLK = ~ACLK;

  return_arbiter #(
    .masters            (2),
    .slaves             (3),
    .i_am_master_number (1)
  ) dut (
    .ACLK                     (ACLK),
    .ARESET                   (ARESET),
    .slave_fifo_empty         (empty),
    .slave_return_dest_master (dest),
    .slave_front_last         (last),
    .master_fifo_full         (full),
    .grant_slave_number       (grant_slave_number),
    .push_to_fifo             (push_to_fifo),
    .grant_valid              (grant_valid)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sample outputs mid-cycle, then advance to just after the next rising edge.
  task automatic step(input string tag, input int p, input int v, input int g);
    @(negedge ACLK);
    check({tag, ".push"},  int'(push_to_fifo),       p);
    check({tag, ".valid"}, int'(grant_valid),        v);
    check({tag, ".grant"}, int'(grant_slave_number), g);
    @(posedge ACLK);
    #1;
  endtask

  task automatic quiet_inputs();
    full = 1'b0;
    for (int s = 0; s < 3; s++) begin
      empty[s] = 1'b1;
      dest[s]  = 1'b1;
      last[s]  = 1'b1;
    end
  endtask

  task automatic apply_reset();
    quiet_inputs();
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    n_compared   = 0;
    n_mismatched = 0;
    ARESET       = 1'b1;
    quiet_inputs();
    for (int s = 0; s < 3; s++) empty[s] = 1'b0;
    @(posedge ACLK);
    #1;

    // Reset held with every slave requesting.
    for (int i = 0; i < 3; i++) step("rst", 0, 0, 0);
    ARESET = 1'b0;

    // Round-robin over all three single-beat requesters, including wrap 2->0.
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      step("rr_idle", 0, 0, prev);
      step("rr_lock", 1, 1, i % 3);
      prev = i % 3;
    end

    // Burst from slave 1 while slave 0 also requests.
    apply_reset();
    empty[1] = 1'b0; last[1] = 1'b0;
    step("bl_c1", 0, 0, 0);
    empty[0] = 1'b0; last[0] = 1'b1;
`ifdef RETURN_ARB_BURST_LOCK_EN
    step("bl_c2", 1, 1, 1);
    step("bl_c3", 1, 1, 1);
    step("bl_c4", 1, 1, 1);
    last[1] = 1'b1;
    step("bl_c5", 1, 1, 1);
    step("bl_c6", 0, 0, 1);
    step("bl_c7", 1, 1, 0);
`else
    step("bl_c2", 1, 1, 1);
    step("bl_c3", 0, 0, 1);
    step("bl_c4", 1, 1, 0);
    last[1] = 1'b1;
    step("bl_c5", 0, 0, 0);
    step("bl_c6", 1, 1, 1);
    step("bl_c7", 0, 0, 1);
`endif

    // Backpressure on a slave 2 burst; full wins over a pending push.
    apply_reset();
    empty[2] = 1'b0; last[2] = 1'b0;
    step("bp_c1", 0, 0, 0);
    step("bp_c2", 1, 1, 2);
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
`ifdef RETURN_ARB_BURST_LOCK_EN
      step("bp_full", 0, 1, 2);
`else
      if (i == 0) step("bp_full", 0, 0, 2);
      else        step("bp_full", 0, 1, 2);
`endif
    end
    full = 1'b0;
    step("bp_c8", 1, 1, 2);
    last[2] = 1'b1;
`ifdef RETURN_ARB_BURST_LOCK_EN
    step("bp_c9", 1, 1, 2);
    empty[2] = 1'b1;
    step("bp_c10", 0, 0, 2);
`else
    step("bp_c9", 0, 0, 2);
    empty[2] = 1'b1;
    step("bp_c10", 0, 1, 2);
`endif

    // Destination filter: slave 0 addresses the other master first.
    apply_reset();
    empty[0] = 1'b0; dest[0] = 1'b0;
    for (int i = 0; i < 3; i++) step("df_other", 0, 0, 0);
    dest[0] = 1'b1;
    step("df_c4", 0, 0, 0);
    step("df_c5", 1, 1, 0);

    // Reset asserted after beat 2 of a slave 1 burst.
    apply_reset();
    empty[1] = 1'b0; last[1] = 1'b0;
    step("rm_c1", 0, 0, 0);
    step("rm_c2", 1, 1, 1);
`ifdef RETURN_ARB_BURST_LOCK_EN
    step("rm_c3", 1, 1, 1);
`else
    step("rm_c3", 0, 0, 1);
`endif
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    step("rm_c5", 0, 0, 0);
    step("rm_c6", 1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
